// File: rtl/rggen_rtl_pkg.sv
// Shared types for the register-block host front end: access and status encodings,
// plus the adapter FSM state.
package rggen_rtl_pkg;

  localparam int RGGEN_ACCESS_DATA_BIT      = 0;
  localparam int RGGEN_ACCESS_NONPOSTED_BIT = 1;

  typedef enum logic [1:0] {
    RGGEN_WRITE        = 2'b11,
    RGGEN_READ         = 2'b10,
    RGGEN_POSTED_WRITE = 2'b01
  } rggen_access;

  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BUSY    = 2'b01,
    RESPOND = 2'b10
  } rggen_adapter_state;

  function automatic rggen_status rggen_error_status(input bit error_status);
    return error_status ? RGGEN_DECODE_ERROR : RGGEN_OKAY;
  endfunction

endpackage

// File: rtl/rggen_or_reducer.sv
// Masked OR of N packed WIDTH-bit entries; selects the hitting register's status/data
// without a priority mux, since at most one register may hit.
module rggen_or_reducer #(
  parameter int WIDTH = 1,
  parameter int N     = 1
) (
  input  logic [N-1:0]       select_i,
  input  logic [WIDTH*N-1:0] data_i,
  output logic [WIDTH-1:0]   data_o
);

  always_comb begin
    data_o = '0;
    for (int i = 0; i < N; i++) begin
      if (select_i[i]) begin
        data_o = data_o | data_i[i*WIDTH+:WIDTH];
      end
    end
  end

endmodule

// File: rtl/rggen_adapter_core.sv
// Host-side adapter: range-checks and latches one host request, broadcasts it to the
// register decoders and returns a single-cycle response strobe.
module rggen_adapter_core
  import rggen_rtl_pkg::*;
#(
  parameter int                     ADDRESS_WIDTH       = 8,
  parameter int                     LOCAL_ADDRESS_WIDTH = 8,
  parameter int                     BUS_WIDTH           = 32,
  parameter int                     REGISTERS           = 1,
  parameter bit [ADDRESS_WIDTH-1:0] BASE_ADDRESS        = '0,
  parameter int                     BYTE_SIZE           = 256,
  parameter bit                     ERROR_STATUS        = 1'b0,
  parameter int                     TIMEOUT             = 0
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_valid,
  input  rggen_access                    i_access,
  input  logic [ADDRESS_WIDTH-1:0]       i_address,
  input  logic [BUS_WIDTH-1:0]           i_write_data,
  input  logic [BUS_WIDTH/8-1:0]         i_strobe,
  output logic                           o_ready,
  output rggen_status                    o_status,
  output logic [BUS_WIDTH-1:0]           o_read_data,
  output logic                           o_register_valid,
  output rggen_access                    o_register_access,
  output logic [LOCAL_ADDRESS_WIDTH-1:0] o_register_address,
  output logic [BUS_WIDTH-1:0]           o_register_write_data,
  output logic [BUS_WIDTH/8-1:0]         o_register_strobe,
  input  logic [REGISTERS-1:0]           i_register_active,
  input  logic [REGISTERS-1:0]           i_register_ready,
  input  logic [2*REGISTERS-1:0]         i_register_status,
  input  logic [BUS_WIDTH*REGISTERS-1:0] i_register_read_data
);

  localparam int                OFS_W      = ADDRESS_WIDTH + 1;
  localparam int                CNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [OFS_W-1:0]  SPAN       = OFS_W'(BYTE_SIZE);
  localparam logic [CNT_W-1:0]  CNT_LAST   = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam rggen_status       ERR_STATUS = rggen_error_status(ERROR_STATUS);

  rggen_adapter_state             state_q, state_d;
  logic [1:0]                     access_q, access_d;
  logic [LOCAL_ADDRESS_WIDTH-1:0] address_q, address_d;
  logic [BUS_WIDTH-1:0]           write_data_q, write_data_d;
  logic [BUS_WIDTH/8-1:0]         strobe_q, strobe_d;
  rggen_status                    status_q, status_d;
  logic [BUS_WIDTH-1:0]           read_data_q, read_data_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;

  logic [OFS_W-1:0]     offset;
  logic                 in_range;
  logic [REGISTERS-1:0] hit_mask;
  logic                 hit;
  logic                 no_active;
  logic                 timed_out;
  logic [1:0]           sel_status;
  logic [BUS_WIDTH-1:0] sel_data;

  // One extra bit keeps addresses below the base from wrapping into range.
  assign offset    = {1'b0, i_address} - {1'b0, BASE_ADDRESS};
  assign in_range  = !offset[ADDRESS_WIDTH] && (offset < SPAN);
  assign hit_mask  = i_register_active & i_register_ready;
  assign hit       = |hit_mask;
  assign no_active = ~|i_register_active;
  assign timed_out = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

  rggen_or_reducer #(
    .WIDTH (2),
    .N     (REGISTERS)
  ) u_status_reducer (
    .select_i (hit_mask),
    .data_i   (i_register_status),
    .data_o   (sel_status)
  );

  rggen_or_reducer #(
    .WIDTH (BUS_WIDTH),
    .N     (REGISTERS)
  ) u_data_reducer (
    .select_i (hit_mask),
    .data_i   (i_register_read_data),
    .data_o   (sel_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          state_d = in_range ? BUSY : RESPOND;
        end
      end
      BUSY: begin
        if (hit || no_active || timed_out) begin
          state_d = RESPOND;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_ready          = (state_q == RESPOND);
    o_register_valid = (state_q == BUSY);
  end

  always_comb begin
    access_d     = access_q;
    address_d    = address_q;
    write_data_d = write_data_q;
    strobe_d     = strobe_q;
    status_d     = status_q;
    read_data_d  = read_data_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          access_d     = i_access;
          address_d    = i_address[LOCAL_ADDRESS_WIDTH-1:0];
          write_data_d = i_write_data;
          strobe_d     = i_strobe;
          cnt_d        = '0;
          if (!in_range) begin
            status_d    = ERR_STATUS;
            read_data_d = '0;
          end
        end
      end
      BUSY: begin
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
        // A real hit wins over a timeout expiring in the same cycle.
        if (hit) begin
          status_d    = rggen_status'(sel_status);
          read_data_d = access_q[RGGEN_ACCESS_DATA_BIT] ? '0 : sel_data;
        end else if (no_active) begin
          status_d    = ERR_STATUS;
          read_data_d = '0;
        end else if (timed_out) begin
          status_d    = RGGEN_SLAVE_ERROR;
          read_data_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      access_q     <= '0;
      address_q    <= '0;
      write_data_q <= '0;
      strobe_q     <= '0;
      status_q     <= RGGEN_OKAY;
      read_data_q  <= '0;
      cnt_q        <= '0;
    end else begin
      access_q     <= access_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
      strobe_q     <= strobe_d;
      status_q     <= status_d;
      read_data_q  <= read_data_d;
      cnt_q        <= cnt_d;
    end
  end

  assign o_status              = status_q;
  assign o_read_data           = read_data_q;
  assign o_register_access     = rggen_access'(access_q);
  assign o_register_address    = address_q;
  assign o_register_write_data = write_data_q;
  assign o_register_strobe     = strobe_q;

`ifdef RGGEN_ENABLE_SVA
  ast_single_active: assert property (@(posedge i_clk) disable iff (i_rst)
    (state_q == BUSY) |-> $onehot0(i_register_active));
`endif

endmodule

// File: tb/tb_rggen_adapter_core.sv
// Bench for rggen_adapter_core: two instances (decode-error + timeout, and okay-on-miss
// without timeout) share one host and one pair of modelled registers.
`timescale 1ns/1ps
module tb_rggen_adapter_core;
  import rggen_rtl_pkg::*;

  localparam int AW    = 12;
  localparam int LAW   = 8;
  localparam int BW    = 32;
  localparam int NREG  = 2;
  localparam int SW    = BW / 8;
  localparam int STW   = 2 * NREG;
  localparam int BASE  = 256;
  localparam int SIZE  = 256;
  localparam int TO_A  = 4;
  localparam int NEVER = 1000;
  localparam int WIN   = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                 valid = 1'b0;
  rggen_access          access = RGGEN_READ;
  logic [AW-1:0]        addr = '0;
  logic [BW-1:0]        wdata = '0;
  logic [SW-1:0]        strobe = '0;
  logic [NREG-1:0]      r_active = '0;
  logic [NREG-1:0]      r_ready = '0;
  logic [STW-1:0]       r_status = '0;
  logic [BW*NREG-1:0]   r_rdata = '0;

  logic        ready_o[2];
  rggen_status st_o[2];
  logic [BW-1:0]  rd_o[2];
  logic        rv_o[2];
  rggen_access racc_o[2];
  logic [LAW-1:0] raddr_o[2];
  logic [BW-1:0]  rwd_o[2];
  logic [SW-1:0]  rstrb_o[2];

  rggen_adapter_core #(
    .ADDRESS_WIDTH(AW), .LOCAL_ADDRESS_WIDTH(LAW), .BUS_WIDTH(BW), .REGISTERS(NREG),
    .BASE_ADDRESS(12'h100), .BYTE_SIZE(SIZE), .ERROR_STATUS(1'b1), .TIMEOUT(TO_A)
  ) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_access(access), .i_address(addr),
    .i_write_data(wdata), .i_strobe(strobe), .o_ready(ready_o[0]), .o_status(st_o[0]),
    .o_read_data(rd_o[0]), .o_register_valid(rv_o[0]), .o_register_access(racc_o[0]),
    .o_register_address(raddr_o[0]), .o_register_write_data(rwd_o[0]),
    .o_register_strobe(rstrb_o[0]), .i_register_active(r_active), .i_register_ready(r_ready),
    .i_register_status(r_status), .i_register_read_data(r_rdata)
  );

  rggen_adapter_core #(
    .ADDRESS_WIDTH(AW), .LOCAL_ADDRESS_WIDTH(LAW), .BUS_WIDTH(BW), .REGISTERS(NREG),
    .BASE_ADDRESS(12'h100), .BYTE_SIZE(SIZE), .ERROR_STATUS(1'b0), .TIMEOUT(0)
  ) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_access(access), .i_address(addr),
    .i_write_data(wdata), .i_strobe(strobe), .o_ready(ready_o[1]), .o_status(st_o[1]),
    .o_read_data(rd_o[1]), .o_register_valid(rv_o[1]), .o_register_access(racc_o[1]),
    .o_register_address(raddr_o[1]), .o_register_write_data(rwd_o[1]),
    .o_register_strobe(rstrb_o[1]), .i_register_active(r_active), .i_register_ready(r_ready),
    .i_register_status(r_status), .i_register_read_data(r_rdata)
  );

  int checks = 0;
  int failures = 0;

  // Observations of one transaction, per instance.
  int             obs_lat[2];
  int             obs_busy[2];
  int             obs_ready[2];
  rggen_status    obs_st[2];
  logic [BW-1:0]  obs_data[2];
  logic [LAW-1:0] obs_addr[2];
  logic [1:0]     obs_acc[2];
  logic [BW-1:0]  obs_wd[2];
  logic [SW-1:0]  obs_strb[2];
  bit             obs_changed[2];

  int             exp_lat[2];
  int             exp_busy[2];
  rggen_status    exp_st[2];
  logic [BW-1:0]  exp_data[2];

  function automatic bit in_range(input int a);
    return (a >= BASE) && (a - BASE < SIZE);
  endfunction

  // Response cycle counted from the cycle i_valid is first seen; release_k is the cycle at
  // which a never-ready register drops active (because the other instance answered).
  function automatic void model(input int a, input logic [1:0] acc, input int hit,
                                input int delay, input bit es, input int to, input int release_k,
                                input logic [1:0] hst, input logic [BW-1:0] hrd,
                                output int lat, output rggen_status st, output logic [BW-1:0] data);
    rggen_status err;
    err = es ? RGGEN_DECODE_ERROR : RGGEN_OKAY;
    data = '0;
    if (!in_range(a)) begin
      lat = 1; st = err;
    end else if (hit < 0) begin
      lat = 2; st = err;
    end else if (to > 0 && delay >= to) begin
      lat = to + 1; st = RGGEN_SLAVE_ERROR;
    end else if (delay == NEVER) begin
      lat = release_k + 1; st = err;
    end else begin
      lat = delay + 2; st = rggen_status'(hst);
      data = acc[0] ? '0 : hrd;
    end
  endfunction

  task automatic set_expect(input int a, input logic [1:0] acc, input int hit, input int delay,
                            input logic [1:0] hst, input logic [BW-1:0] hrd);
    model(a, acc, hit, delay, 1'b1, TO_A, 0, hst, hrd, exp_lat[0], exp_st[0], exp_data[0]);
    model(a, acc, hit, delay, 1'b0, 0, exp_lat[0], hst, hrd, exp_lat[1], exp_st[1], exp_data[1]);
    for (int d = 0; d < 2; d++) exp_busy[d] = in_range(a) ? exp_lat[d] - 1 : 0;
  endtask

  task automatic run_txn(input int a, input logic [1:0] acc, input logic [BW-1:0] wd,
                         input logic [SW-1:0] sb, input int hit, input int delay,
                         input bit drop_early, input logic [1:0] hst, input logic [BW-1:0] hrd);
    @(negedge clk);
    valid = 1'b1; access = rggen_access'(acc); addr = AW'(a); wdata = wd; strobe = sb;
    r_rdata = {$urandom, $urandom};
    r_status = STW'($urandom);
    r_ready = '0;
    r_active = '0;
    if (hit >= 0) begin
      r_rdata[hit*BW+:BW] = hrd;
      r_status[hit*2+:2] = hst;
      r_active = NREG'(1) << hit;
    end
    for (int d = 0; d < 2; d++) begin
      obs_lat[d] = -1; obs_busy[d] = 0; obs_ready[d] = 0; obs_changed[d] = 1'b0;
      obs_st[d] = RGGEN_OKAY; obs_data[d] = '0;
    end
    for (int k = 1; k <= WIN; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (ready_o[d]) begin
          obs_ready[d]++;
          if (obs_lat[d] < 0) begin
            obs_lat[d] = k; obs_st[d] = st_o[d]; obs_data[d] = rd_o[d];
          end
        end
        if (rv_o[d]) begin
          if (obs_busy[d] == 0) begin
            obs_addr[d] = raddr_o[d]; obs_acc[d] = racc_o[d];
            obs_wd[d] = rwd_o[d]; obs_strb[d] = rstrb_o[d];
          end else if (obs_addr[d] !== raddr_o[d] || obs_acc[d] !== racc_o[d] ||
                       obs_wd[d] !== rwd_o[d] || obs_strb[d] !== rstrb_o[d]) begin
            obs_changed[d] = 1'b1;
          end
          obs_busy[d]++;
        end
      end
      if (valid && (ready_o[0] || ready_o[1] || (drop_early && k == 1))) begin
        valid = 1'b0;
        access = rggen_access'(2'($urandom));
        addr = AW'($urandom); wdata = $urandom; strobe = SW'($urandom);
      end
      if (delay == NEVER && (ready_o[0] || ready_o[1])) r_active = '0;
      if (hit >= 0 && delay != NEVER && k >= delay + 1) r_ready = NREG'(1) << hit;
    end
    valid = 1'b0; r_active = '0; r_ready = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ready_o[d] !== 1'b0 || rv_o[d] !== 1'b0) begin
        failures++; $display("FAIL reset_strobes dut%0d: ready=%b reg_valid=%b want 0/0", d, ready_o[d], rv_o[d]);
      end
      checks++;
      if (st_o[d] !== RGGEN_OKAY || rd_o[d] !== '0) begin
        failures++; $display("FAIL reset_response dut%0d: status=%0d data=%h want 0/0", d, st_o[d], rd_o[d]);
      end
      checks++;
      if (racc_o[d] !== 2'b00 || raddr_o[d] !== '0 || rwd_o[d] !== '0 || rstrb_o[d] !== '0) begin
        failures++; $display("FAIL reset_payload dut%0d: acc=%0d addr=%h wd=%h strb=%h want all 0",
                             d, racc_o[d], raddr_o[d], rwd_o[d], rstrb_o[d]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_read_hit();
    run_txn(32'h104, 2'b10, '0, '1, 1, 0, 1'b0, 2'b00, 32'hDEADBEEF);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs_lat[d] !== 2) begin
        failures++; $display("FAIL read_hit_latency dut%0d: got %0d want 2", d, obs_lat[d]);
      end
      checks++;
      if (obs_st[d] !== RGGEN_OKAY || obs_data[d] !== 32'hDEADBEEF) begin
        failures++; $display("FAIL read_hit_resp dut%0d: status=%0d data=%h want 0/deadbeef", d, obs_st[d], obs_data[d]);
      end
    end
  endtask

  task automatic test_write_stretch();
    run_txn(32'h108, 2'b11, 32'h12345678, 4'b0011, 0, 3, 1'b0, 2'b00, 32'hA5A5A5A5);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs_lat[d] !== 5 || obs_busy[d] !== 4) begin
        failures++; $display("FAIL write_timing dut%0d: lat=%0d busy=%0d want 5/4", d, obs_lat[d], obs_busy[d]);
      end
      checks++;
      if (obs_addr[d] !== 8'h08 || obs_acc[d] !== 2'b11 || obs_wd[d] !== 32'h12345678 ||
          obs_strb[d] !== 4'b0011 || obs_changed[d]) begin
        failures++; $display("FAIL write_payload dut%0d: addr=%h acc=%0d wd=%h strb=%h changed=%0d want 08/3/12345678/3/0",
                             d, obs_addr[d], obs_acc[d], obs_wd[d], obs_strb[d], obs_changed[d]);
      end
      checks++;
      if (obs_st[d] !== RGGEN_OKAY || obs_data[d] !== '0) begin
        failures++; $display("FAIL write_resp dut%0d: status=%0d data=%h want 0/0", d, obs_st[d], obs_data[d]);
      end
    end
  endtask

  task automatic test_out_of_range();
    run_txn(32'h040, 2'b10, '0, '1, 0, 0, 1'b0, 2'b01, 32'h11111111);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs_lat[d] !== 1 || obs_busy[d] !== 0) begin
        failures++; $display("FAIL oor_timing dut%0d: lat=%0d busy=%0d want 1/0", d, obs_lat[d], obs_busy[d]);
      end
      checks++;
      if (obs_st[d] !== (d == 0 ? RGGEN_DECODE_ERROR : RGGEN_OKAY) || obs_data[d] !== '0) begin
        failures++; $display("FAIL oor_resp dut%0d: status=%0d data=%h want %0d/0", d, obs_st[d], obs_data[d], d == 0 ? 3 : 0);
      end
    end
  endtask

  task automatic test_no_hit();
    run_txn(32'h1F0, 2'b10, '0, '1, -1, 0, 1'b0, 2'b00, '0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs_lat[d] !== 2 || obs_st[d] !== (d == 0 ? RGGEN_DECODE_ERROR : RGGEN_OKAY) || obs_data[d] !== '0) begin
        failures++; $display("FAIL no_hit dut%0d: lat=%0d status=%0d data=%h want 2/%0d/0",
                             d, obs_lat[d], obs_st[d], obs_data[d], d == 0 ? 3 : 0);
      end
    end
  endtask

  task automatic test_timeout();
    run_txn(32'h110, 2'b10, '0, '1, 0, NEVER, 1'b0, 2'b00, 32'hCAFEF00D);
    checks++;
    if (obs_lat[0] !== 5 || obs_st[0] !== RGGEN_SLAVE_ERROR || obs_data[0] !== '0) begin
      failures++; $display("FAIL timeout dut0: lat=%0d status=%0d data=%h want 5/2/0", obs_lat[0], obs_st[0], obs_data[0]);
    end
    checks++;
    if (obs_lat[1] !== 6 || obs_st[1] !== RGGEN_OKAY || obs_busy[1] !== 5) begin
      failures++; $display("FAIL no_timeout_release dut1: lat=%0d status=%0d busy=%0d want 6/0/5", obs_lat[1], obs_st[1], obs_busy[1]);
    end
  endtask

  task automatic test_reset_in_busy();
    @(negedge clk);
    valid = 1'b1; access = RGGEN_READ; addr = 12'h110; r_active = 2'b01; r_ready = '0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rv_o[d] !== 1'b1) begin
        failures++; $display("FAIL rst_busy_enter dut%0d: reg_valid=%b want 1", d, rv_o[d]);
      end
    end
    rst = 1'b1; valid = 1'b0; r_active = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (rv_o[d] !== 1'b0 || ready_o[d] !== 1'b0) begin
          failures++; $display("FAIL rst_busy_quiet dut%0d cyc%0d: reg_valid=%b ready=%b want 0/0", d, k, rv_o[d], ready_o[d]);
        end
      end
      @(negedge clk);
    end
    run_txn(32'h1FC, 2'b10, '0, '1, 0, 1, 1'b0, 2'b00, 32'h0BADF00D);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs_lat[d] !== 3 || obs_data[d] !== 32'h0BADF00D) begin
        failures++; $display("FAIL rst_busy_after dut%0d: lat=%0d data=%h want 3/0badf00d", d, obs_lat[d], obs_data[d]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int a, hit, delay;
    logic [1:0] acc, hst;
    logic [BW-1:0] wd, hrd;
    logic [SW-1:0] sb;
    bit drop;
    for (int n = 0; n < 40; n++) begin
      a = int'($urandom_range(32'h0C0, 32'h23F));
      case ($urandom_range(0, 2))
        0: acc = 2'b10;
        1: acc = 2'b11;
        default: acc = 2'b01;
      endcase
      hit = int'($urandom_range(0, 2)) - 1;
      delay = int'($urandom_range(0, 6));
      drop = 1'($urandom);
      hst = 2'($urandom); wd = $urandom; hrd = $urandom; sb = SW'($urandom);
      set_expect(a, acc, hit, delay, hst, hrd);
      run_txn(a, acc, wd, sb, hit, delay, drop, hst, hrd);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs_lat[d] !== exp_lat[d] || obs_ready[d] !== 1 || obs_busy[d] !== exp_busy[d]) begin
          failures++; $display("FAIL rand_timing n%0d dut%0d a=%h: lat=%0d pulses=%0d busy=%0d want %0d/1/%0d",
                               n, d, a, obs_lat[d], obs_ready[d], obs_busy[d], exp_lat[d], exp_busy[d]);
        end
        checks++;
        if (obs_st[d] !== exp_st[d] || obs_data[d] !== exp_data[d]) begin
          failures++; $display("FAIL rand_resp n%0d dut%0d a=%h: status=%0d data=%h want %0d/%h",
                               n, d, a, obs_st[d], obs_data[d], exp_st[d], exp_data[d]);
        end
        if (exp_busy[d] > 0) begin
          checks++;
          if (obs_addr[d] !== LAW'(a) || obs_acc[d] !== acc || obs_wd[d] !== wd ||
              obs_strb[d] !== sb || obs_changed[d]) begin
            failures++; $display("FAIL rand_payload n%0d dut%0d: addr=%h acc=%0d wd=%h strb=%h changed=%0d want %h/%0d/%h/%h/0",
                                 n, d, obs_addr[d], obs_acc[d], obs_wd[d], obs_strb[d], obs_changed[d],
                                 LAW'(a), acc, wd, sb);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_write_stretch();
    test_out_of_range();
    test_no_hit();
    test_timeout();
    test_reset_in_busy();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
